lcd_init_sequencer: RTL and testbench
=====================================

LCD_INIT_SEQUENCER -- requirements
Module: lcd_init_sequencer

Interface
REQ-001 Parameter RESET_LOW_CYC, default 160, SHALL set the RESX low time in CLK cycles (10 us at 16 MHz).
REQ-002 Parameter RESET_WAIT_CYC, default 1920000, SHALL set the wait after RESX release in cycles (120 ms).
REQ-003 Parameter SLPOUT_WAIT_CYC, default 1920000, SHALL set the wait after the SLPOUT command in cycles.
REQ-004 Parameter NUM_PIX_BYTES, default 230400, SHALL set the pixel bytes per frame (240x320x3).
REQ-005 CLK  in  1: 16 MHz clock; all logic SHALL be on its rising edge.
REQ-006 RST  in  1: reset; one clock, reset synchronous and active-high.
REQ-007 START  in  1: single-cycle request to begin reset, init and one frame.
REQ-008 RESX  out  1: panel hardware reset, active low.
REQ-009 TX_VALID / TX_READY  out / in  1 each: byte handshake to the SPI serializer.
REQ-010 TX_DATA  out  8: byte to send.
REQ-011 TX_DC  out  1: 0 = command byte, 1 = data byte.
REQ-012 TX_LAST  out  1: serializer deasserts CSX after this byte.
REQ-013 PIX_VALID / PIX_READY  in / out  1 each, plus PIX_DATA  in  8: upstream pixel byte stream.
REQ-014 BUSY  out  1: high in every state except IDLE.
REQ-015 DONE  out  1: single-cycle pulse when a frame completes.

Function
REQ-016 The FSM SHALL have states IDLE, RST_LOW, RST_WAIT, CMD_SEND, DELAY and STREAM.
REQ-017 IDLE: START=1 SHALL move to RST_LOW next cycle; START in any other state SHALL be ignored.
REQ-018 RST_LOW SHALL drive RESX=0 for exactly RESET_LOW_CYC cycles, then go to RST_WAIT with RESX=1.
REQ-019 RST_WAIT SHALL last exactly RESET_WAIT_CYC cycles, then go to CMD_SEND at ROM index 0.
REQ-020 The init ROM SHALL be fixed, in order (DC,byte,LAST):
- (0,0x11,1) SLPOUT, then delay flag
- (0,0x3A,0), (1,0x66,1) COLMOD 18-bit
- (0,0x36,0), (1,0x00,1) MADCTL
- (0,0x29,1) DISPON
- (0,0x2C,0) RAMWR, end flag
REQ-021 CMD_SEND SHALL present TX_VALID=1 with TX_DATA, TX_DC and TX_LAST from the current ROM entry.
REQ-022 TX_DATA, TX_DC and TX_LAST SHALL hold stable while TX_VALID=1 and TX_READY=0.
REQ-023 A transfer SHALL occur on a cycle with TX_VALID=1 and TX_READY=1; the ROM index SHALL advance that cycle.
REQ-024 After a transfer of the delay-flagged entry, the FSM SHALL enter DELAY for SLPOUT_WAIT_CYC cycles with TX_VALID=0, then return to CMD_SEND.
REQ-025 After a transfer of the end-flagged entry, the FSM SHALL enter STREAM with the pixel counter cleared.
REQ-026 In STREAM, the following SHALL be combinational pass-through:
- TX_VALID=PIX_VALID, PIX_READY=TX_READY, TX_DATA=PIX_DATA
- TX_DC=1
- TX_LAST=1 only on byte index NUM_PIX_BYTES-1
REQ-027 PIX_READY SHALL be 0 in every state other than STREAM.
REQ-028 The pixel counter SHALL be 18 bits and increment once per transfer, never wrapping.
REQ-029 On the final pixel transfer, the FSM SHALL go to IDLE and pulse DONE=1 for exactly one cycle.
REQ-030 Delay counters SHALL be 21 bits, cleared on state entry.
REQ-031 Each wait SHALL end when the counter equals its parameter minus 1.
REQ-032 TX_READY held at 0 SHALL stall indefinitely without timeout, and no byte SHALL be dropped or duplicated.

Reset
REQ-033 RST=1 SHALL force IDLE in any state, including mid-transfer or mid-delay.
REQ-034 During reset, outputs SHALL be: RESX=1, TX_VALID=0, TX_DATA=0, TX_DC=0, TX_LAST=0, PIX_READY=0, BUSY=0, DONE=0.
REQ-035 During reset, counters and the ROM index SHALL clear to 0.
REQ-036 START asserted during RST=1 SHALL be ignored.

Verification (RESET_LOW_CYC=4, RESET_WAIT_CYC=8, SLPOUT_WAIT_CYC=8, NUM_PIX_BYTES=6, unless noted)
REQ-037 START pulse, TX_READY=1 -> RESX low exactly 4 cycles, 8 idle cycles, then TX bytes 0x11 with DC=0 and LAST=1.
REQ-038 Continue REQ-037 -> 8-cycle gap, then:
- 0x3A/0x66, 0x36/0x00, 0x29, 0x2C
- DC pattern 0,1,0,1,0,0
- LAST pattern 1,1,1,0
REQ-039 TX_READY held 0 for 5 cycles on 0x3A -> TX_DATA/TX_DC/TX_LAST stable; exactly one 0x3A is transferred.
REQ-040 STREAM with PIX bytes 0xA0..0xA5 and PIX_VALID toggling -> six bytes with DC=1, LAST only on 0xA5, one-cycle DONE, BUSY=0 next cycle.
REQ-041 RST=1 for 1 cycle during DELAY -> all outputs at reset values next cycle; a new START restarts from RST_LOW.
REQ-042 START pulse during STREAM -> no effect on the byte sequence or counters.

Source files
------------

// File: rtl/lcd_init_sequencer_if.sv
// Byte-stream bundle for the LCD init sequencer.
//   tx_*  : byte handshake towards the SPI serializer (valid/ready, data, D/C, last)
//   pix_* : upstream pixel byte stream (valid/ready, data)
// master : the sequencer side; slave : serializer plus pixel-source side.
interface lcd_init_sequencer_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_dc;
  logic       tx_last;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] pix_data;

  modport master (
    output tx_valid, tx_data, tx_dc, tx_last, pix_ready,
    input  tx_ready, pix_valid, pix_data
  );

  modport slave (
    input  tx_valid, tx_data, tx_dc, tx_last, pix_ready,
    output tx_ready, pix_valid, pix_data
  );
endinterface

// File: rtl/lcd_init_sequencer.sv
// LCD panel bring-up sequencer. On a start pulse it pulses RESX low, waits,
// sends a fixed init command list (with a post-SLPOUT delay) and then passes
// one frame of pixel bytes straight through to the serializer.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   start    : single-cycle request (honoured only in IDLE)
//   resx     : panel hardware reset, active low
//   busy     : high in every state except IDLE
//   done     : one-cycle pulse when the last pixel byte is transferred
//   bus      : tx_* serializer handshake and pix_* upstream stream
module lcd_init_sequencer #(
  parameter int RESET_LOW_CYC   = 160,
  parameter int RESET_WAIT_CYC  = 1920000,
  parameter int SLPOUT_WAIT_CYC = 1920000,
  parameter int NUM_PIX_BYTES   = 230400
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 resx,
  output logic                 busy,
  output logic                 done,
  lcd_init_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, RST_LOW, RST_WAIT, CMD_SEND, DELAY, STREAM
  } state_t;

  localparam logic [20:0] LOW_LAST = 21'(RESET_LOW_CYC - 1);
  localparam logic [20:0] WAIT_LAST = 21'(RESET_WAIT_CYC - 1);
  localparam logic [20:0] SLP_LAST = 21'(SLPOUT_WAIT_CYC - 1);
  localparam logic [17:0] PIX_LAST = 18'(NUM_PIX_BYTES - 1);

  state_t      state;
  logic [20:0] cnt;
  logic [2:0]  rom_idx;
  logic [17:0] pix_cnt;
  logic [11:0] rom;

  // ROM word: {dc, last, delay_flag, end_flag, byte}
  function automatic logic [11:0] rom_entry(input logic [2:0] idx);
    case (idx)
      3'd0:    rom_entry = {4'b0110, 8'h11};  // SLPOUT, then delay
      3'd1:    rom_entry = {4'b0000, 8'h3A};  // COLMOD
      3'd2:    rom_entry = {4'b1100, 8'h66};  // 18-bit colour
      3'd3:    rom_entry = {4'b0000, 8'h36};  // MADCTL
      3'd4:    rom_entry = {4'b1100, 8'h00};
      3'd5:    rom_entry = {4'b0100, 8'h29};  // DISPON
      3'd6:    rom_entry = {4'b0001, 8'h2C};  // RAMWR, then stream
      default: rom_entry = 12'h000;
    endcase
  endfunction

  assign rom = rom_entry(rom_idx);

  // Byte outputs are decoded from registered state only, except in STREAM
  // where the pixel handshake is a combinational pass-through.
  always_comb begin
    bus.tx_valid  = 1'b0;
    bus.tx_data   = 8'h00;
    bus.tx_dc     = 1'b0;
    bus.tx_last   = 1'b0;
    bus.pix_ready = 1'b0;
    case (state)
      CMD_SEND: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = rom[7:0];
        bus.tx_dc    = rom[11];
        bus.tx_last  = rom[10];
      end
      STREAM: begin
        bus.tx_valid  = bus.pix_valid;
        bus.pix_ready = bus.tx_ready;
        bus.tx_data   = bus.pix_data;
        bus.tx_dc     = 1'b1;
        bus.tx_last   = (pix_cnt == PIX_LAST);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rom_idx <= '0;
      pix_cnt <= '0;
      resx    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RST_LOW;
            resx  <= 1'b0;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        RST_LOW: begin
          if (cnt == LOW_LAST) begin
            state <= RST_WAIT;
            resx  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 21'd1;
          end
        end
        RST_WAIT: begin
          if (cnt == WAIT_LAST) begin
            state   <= CMD_SEND;
            rom_idx <= '0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 21'd1;
          end
        end
        CMD_SEND: begin
          if (bus.tx_ready) begin
            rom_idx <= rom_idx + 3'd1;
            if (rom[8]) begin
              state   <= STREAM;
              pix_cnt <= '0;
            end else if (rom[9]) begin
              state <= DELAY;
              cnt   <= '0;
            end
          end
        end
        DELAY: begin
          if (cnt == SLP_LAST) begin
            state <= CMD_SEND;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 21'd1;
          end
        end
        STREAM: begin
          // The counter stops at the final byte, so it can never wrap.
          if (bus.pix_valid && bus.tx_ready) begin
            if (pix_cnt == PIX_LAST) begin
              state <= IDLE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              pix_cnt <= pix_cnt + 18'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Self-checking bench for lcd_init_sequencer with short wait parameters.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at the falling edge, where a monitor logs every tx handshake.
module tb_lcd_init_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic resx;
  logic busy;
  logic done;

  lcd_init_sequencer_if bus();

  lcd_init_sequencer #(
    .RESET_LOW_CYC  (4),
    .RESET_WAIT_CYC (8),
    .SLPOUT_WAIT_CYC(8),
    .NUM_PIX_BYTES  (6)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .resx (resx),
    .busy (busy),
    .done (done),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       dc;
    logic       last;
  } xfer_t;

  typedef struct {
    logic [7:0] pix;
    logic       exp_last;
  } pix_vec_t;

  xfer_t    init_tab[7];
  pix_vec_t pix_tab[6];

  int n_tests = 0;
  int n_fail  = 0;

  int         cyc = 0;
  int         low_cnt = 0;
  int         last_low_cyc = 0;
  int         done_cnt = 0;
  logic [7:0] q_data[$];
  logic       q_dc[$];
  logic       q_last[$];
  int         q_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (resx === 1'b0) begin
      low_cnt++;
      last_low_cyc = cyc;
    end
    if (done === 1'b1) done_cnt++;
    if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
      q_data.push_back(bus.tx_data);
      q_dc.push_back(bus.tx_dc);
      q_last.push_back(bus.tx_last);
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_xfers(input int n, input int budget);
    int k = 0;
    while (q_data.size() < n && k < budget) begin
      sample();
      k++;
    end
    chk("wait_xfers", 32'(q_data.size() >= n), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_resx"},      32'(resx),          32'd1);
    chk({tag, "_tx_valid"},  32'(bus.tx_valid),  32'd0);
    chk({tag, "_tx_data"},   32'(bus.tx_data),   32'd0);
    chk({tag, "_tx_dc"},     32'(bus.tx_dc),     32'd0);
    chk({tag, "_tx_last"},   32'(bus.tx_last),   32'd0);
    chk({tag, "_pix_ready"}, 32'(bus.pix_ready), 32'd0);
    chk({tag, "_busy"},      32'(busy),          32'd0);
    chk({tag, "_done"},      32'(done),          32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap_cyc;
    int n3a;
    bit found;

    init_tab[0] = '{8'h11, 1'b0, 1'b1};
    init_tab[1] = '{8'h3A, 1'b0, 1'b0};
    init_tab[2] = '{8'h66, 1'b1, 1'b1};
    init_tab[3] = '{8'h36, 1'b0, 1'b0};
    init_tab[4] = '{8'h00, 1'b1, 1'b1};
    init_tab[5] = '{8'h29, 1'b0, 1'b1};
    init_tab[6] = '{8'h2C, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) pix_tab[i] = '{8'hA0 + 8'(i), (i == 5)};

    // Reset with start held high: start must be ignored.
    rst = 1'b1;
    start = 1'b1;
    bus.tx_ready = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_data = 8'h00;
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    start = 1'b0;
    repeat (3) step();
    chk("idle_after_reset_busy", 32'(busy), 32'd0);
    chk("idle_after_reset_resx", 32'(resx), 32'd1);

    // Full bring-up with a stall on 0x3A.
    bus.tx_ready = 1'b1;
    low_cnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (bus.tx_valid === 1'b1 && bus.tx_data === 8'h3A) begin
        found = 1'b1;
        break;
      end
    end
    chk("found_3a", 32'(found), 32'd1);
    chk("resx_low_cycles", 32'(low_cnt), 32'd4);
    chk("first_tx_gap", 32'(q_cyc[0] - last_low_cyc), 32'd9);
    bus.tx_ready = 1'b0;
    gap_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      sample();
      if (k == 0) gap_cyc = cyc;
      chk("stall_valid", 32'(bus.tx_valid), 32'd1);
      chk("stall_data", 32'(bus.tx_data), 32'h3A);
      chk("stall_dc", 32'(bus.tx_dc), 32'd0);
      chk("stall_last", 32'(bus.tx_last), 32'd0);
      chk("stall_pix_ready", 32'(bus.pix_ready), 32'd0);
      step();
    end
    bus.tx_ready = 1'b1;
    chk("slpout_gap", 32'(gap_cyc - q_cyc[0]), 32'd9);
    wait_xfers(7, 200);
    chk("3a_after_stall", 32'(q_cyc[1] - gap_cyc), 32'd5);
    n3a = 0;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("init%0d_data", i), 32'(q_data[i]), 32'(init_tab[i].data));
      chk($sformatf("init%0d_dc", i), 32'(q_dc[i]), 32'(init_tab[i].dc));
      chk($sformatf("init%0d_last", i), 32'(q_last[i]), 32'(init_tab[i].last));
      if (q_data[i] == 8'h3A) n3a++;
    end
    chk("count_3a", 32'(n3a), 32'd1);

    // Pixel stream with valid toggling and a stray start pulse.
    done_cnt = 0;
    step();
    for (int i = 0; i < 6; i++) begin
      bus.pix_valid = 1'b0;
      bus.pix_data = 8'hFF;
      if (i == 2) start = 1'b1;
      step();
      start = 1'b0;
      bus.pix_valid = 1'b1;
      bus.pix_data = pix_tab[i].pix;
      step();
    end
    bus.pix_valid = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    step();
    chk("done_cleared", 32'(done), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    repeat (4) step();
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("xfer_total", 32'(q_data.size()), 32'd13);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("pix%0d_data", i), 32'(q_data[7 + i]), 32'(pix_tab[i].pix));
      chk($sformatf("pix%0d_dc", i), 32'(q_dc[7 + i]), 32'd1);
      chk($sformatf("pix%0d_last", i), 32'(q_last[7 + i]), 32'(pix_tab[i].exp_last));
    end

    // Reset during DELAY, with start asserted alongside reset.
    q_data.delete();
    q_dc.delete();
    q_last.delete();
    q_cyc.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_xfers(1, 100);
    repeat (3) step();
    chk("in_delay_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    start = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    check_reset_outputs("mid_delay_reset");
    repeat (20) step();
    chk("no_xfer_after_reset", 32'(q_data.size()), 32'd1);
    chk("idle_after_reset", 32'(busy), 32'd0);

    // Fresh start must begin again from the RESX pulse.
    low_cnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_resx_low", 32'(resx), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    wait_xfers(2, 100);
    chk("restart_low_cycles", 32'(low_cnt), 32'd4);
    chk("restart_first_byte", 32'(q_data[1]), 32'h11);
    chk("restart_gap", 32'(q_cyc[1] - last_low_cyc), 32'd9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
